bin2bcd_seq_16: RTL
===================

# bin2bcd_seq_16

Sequential 16-bit binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between the 16-bit event counter and the five hex_to_7seg decoders. It replaces the combinational converter where timing or area matters. Results are held in registers, so the display never shows intermediate values while a conversion runs.

## Interface
- No parameters; input width is fixed at 16 bits and output at 5 BCD digits.
- clock  input  1  system clock (CLOCK_50 at top level)
- reset  input  1  synchronous, active-high; one clock; no other clock domains
- start  input  1  request a conversion of bin; sampled only in IDLE
- bin  input  16  unsigned binary value; captured on the accepting edge
- busy  output  1  high while a conversion is in progress
- done  output  1  single-cycle pulse when BCD0..BCD4 update
- BCD0  output  4  units digit
- BCD1  output  4  tens digit
- BCD2  output  4  hundreds digit
- BCD3  output  4  thousands digit
- BCD4  output  4  ten-thousands digit (0..6)

## Operation
- Internal state:
  - 16-bit binary shift register
  - 20-bit BCD scratch register
  - 5-bit bit counter
  - states IDLE and CONV
- IDLE, start=1:
  - load the shift register with bin and clear the scratch register and counter
  - go to CONV; busy=1 from the next cycle
- IDLE, start=0: hold.
- CONV, each clock:
  - for every scratch digit that is ≥5, add 3 to it
  - shift {scratch, shift_reg} left by 1
  - increment the counter
- Add-3 and shift happen in the same cycle. The add-3 acts on the pre-shift value.
- On the 16th CONV edge (counter = 15):
  - write the final adjusted and shifted scratch value to BCD4..BCD0
  - pulse done=1, clear busy, return to IDLE
- BCD outputs change only on that edge. They hold the previous result for the whole conversion.
- start while busy is ignored; it is not queued.
- bin changes after the accepting edge do not affect the result.
- Digit values are always 0..9. BCD4 is never greater than 6.

## Timing
- Reset values:
  - BCD0..BCD4 = 0, busy = 0, done = 0, state = IDLE, counter = 0
- reset has priority over start and over any in-flight conversion.
- Reset mid-conversion aborts immediately: outputs go to 0, and no done pulse is generated.
- Latency: start accepted at edge k, then CONV runs edges k+1..k+16.
  - BCD outputs update and done=1 during the cycle after edge k+16.
  - busy=1 for exactly 16 cycles.
- Throughput: start may be high in the done cycle (state is already IDLE) and is accepted. This gives back-to-back conversions every 17 cycles.
- done is registered and exactly one cycle wide. busy and done are never high together.
- start held continuously high: the block re-converts every 17 cycles.

## Test plan
- Reset, then start with bin=0:
  - done arrives 17 cycles after the start edge
  - all digits 0, busy high for 16 cycles
- bin=65535 (max): digits 6,5,5,3,5 (BCD4..BCD0). No digit exceeds 9.
- bin=12345, then bin=9999 and 10000 (digit-carry boundaries):
  - 1,2,3,4,5
  - 0,9,9,9,9
  - 1,0,0,0,0
- Start with bin=500, then change bin to 777 and pulse start during busy:
  - result is 0,0,5,0,0
  - only one done pulse
  - previous outputs hold until done
- Reset asserted at CONV cycle 8 of bin=4321:
  - outputs 0 on the next cycle, no done pulse
  - a following start with bin=4321 yields 0,4,3,2,1
- start held high with bin stepping 1,2,3 at each done:
  - done pulses every 17 cycles
  - outputs 0,0,0,0,1 then 0,0,0,0,2 then 0,0,0,0,3

Source files
------------

// File: rtl/bin2bcd_seq_16_if.sv
// Request/result bundle between the event counter side and the 7-seg decoders.
// The host starts a conversion; the converter returns the held BCD digits.
interface bin2bcd_seq_16_if;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  BCD0;
  logic [3:0]  BCD1;
  logic [3:0]  BCD2;
  logic [3:0]  BCD3;
  logic [3:0]  BCD4;

  modport master (output start, bin, input busy, done, BCD0, BCD1, BCD2, BCD3, BCD4);
  modport slave  (input start, bin, output busy, done, BCD0, BCD1, BCD2, BCD3, BCD4);
endinterface

// File: rtl/bin2bcd_seq_16.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble, one bit per clock).
// Results are registered, so the display holds the last value while a conversion runs.
module bin2bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq_16 (
  input  logic              clock,
  input  logic              reset,
  bin2bcd_seq_16_if.slave   bus
);
  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_nx;
  logic [15:0]     sr;
  logic [4:0][3:0] scr, adj, bcd_q;
  logic [19:0]     shifted;
  logic [4:0]      cnt;
  logic            last;
  logic            done_q;

  for (genvar g = 0; g < 5; g++) begin : g_dig
    bin2bcd_add3 u_add3 (.d(scr[g]), .q(adj[g]));
  end

  // Adjust acts on the pre-shift digits; the top bit of digit 4 can never be set.
  assign shifted = {adj[4][2:0], adj[3], adj[2], adj[1], adj[0], sr[15]};
  assign last    = (cnt == 5'd15);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = CONV;
      CONV:    if (last)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CONV);
    bus.done = done_q;
    bus.BCD0 = bcd_q[0];
    bus.BCD1 = bcd_q[1];
    bus.BCD2 = bcd_q[2];
    bus.BCD3 = bcd_q[3];
    bus.BCD4 = bcd_q[4];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr     <= '0;
      scr    <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          sr  <= bus.bin;
          scr <= '0;
          cnt <= '0;
        end
        CONV: begin
          sr  <= {sr[14:0], 1'b0};
          scr <= shifted;
          cnt <= cnt + 5'd1;
          if (last) begin
            bcd_q  <= shifted;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
